pipe_control_unit: RTL and testbench
====================================

Name: pipe_control_unit

Overview:
Five-stage pipelined successor to the single-cycle control unit. It decodes the instruction in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. It resolves pc_src in EX and contains load-use hazard detection, flush/bubble control and EX-operand forwarding selects. The datapath keeps only data registers; every control bit and destination-register tag lives here.

Parameters:
ALU_CTRL_W, 4, alu_control width. Encodings: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
REG_ADDR_W, 5, register-index width.
FORWARD_EN, 1, 1 enables forwarding; 0 ties forward_a_e and forward_b_e to 00 and stalls on any RAW hazard within 3 instructions.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
op_d  in  7  ID opcode
funct3_d  in  3  ID funct3
funct7_d  in  7  ID funct7 (bit 5 used)
rs1_d, rs2_d, rd_d  in  REG_ADDR_W  ID register indices
zero_e  in  1  EX ALU zero flag
imm_src_d  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational)
illegal_d  out  1  unknown opcode in ID (combinational)
alu_control_e  out  ALU_CTRL_W  EX ALU operation
alu_src_e  out  1  EX ALU B-operand select: 1 immediate
pc_src_e  out  1  redirect PC (combinational from EX regs)
jalr_e  out  1  PC target from ALU rather than PC+imm
forward_a_e, forward_b_e  out  2  00 register file, 01 WB result, 10 MEM ALU result
mem_write_m  out  1  data-memory write in MEM
reg_write_w  out  1  register-file write in WB
result_src_w  out  2  00 ALU, 01 memory, 10 PC+4
rd_w  out  REG_ADDR_W  WB destination register
stall_f, stall_d, flush_d  out  1  hazard controls to the datapath

Behaviour:
- Reset: all pipeline registers clear to 0 (bubble). All registered outputs are 0 and pc_src_e is 0.
- Decode is combinational. r/i-type: alu_control comes from funct3 and funct7[5]; the sub/sra distinction applies to r-type only, plus srai. lw: add, alu_src 1, result 01. sw: add, mem_write. beq/bne: sub, branch, funct3 carried. jal: jump, result 10. jalr: jump, jalr, alu_src 1, add. lui: alu_src 1, imm U, add with rs1 forced to 0 by the datapath.
- Illegal opcode: all write/branch/jump controls are 0 and illegal_d is 1. The instruction becomes a bubble.
- pc_src_e = jump_e | (branch_e & (funct3_e==000 ? zero_e : ~zero_e)). Other branch funct3 values give 0.
- lw_stall = (result_src_e==01) & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- stall_f = stall_d = lw_stall. flush_d = pc_src_e. ID/EX loads a bubble when lw_stall | pc_src_e.
- If lw_stall and pc_src_e are both 1, the flush wins. stall_f still asserts, which is harmless because the PC is redirected.
- EX/MEM and MEM/WB always advance; only ID/EX is flushable.
- Forward A:
  - 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e.
  - else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e.
  - else 00.
  - MEM has priority over WB.
  - B is the same using rs2_e.
- x0 is never a hazard or forward source.
- Latency: decode to EX outputs is 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- Reset mid-operation clears all stages asynchronously. No write occurs in the following cycle.

Decomposition:
- Package pipe_ctrl_pkg holds the opcode constants, the imm_src, result_src and alu_control encodings, the forward-select encodings, and the control-bundle widths.
- Sub-module pipe_main_alu_decoder: combinational decode of op/funct3/funct7 into the bundle plus illegal.
- The top holds the pipeline registers, the hazard unit and the forwarding logic.

Test Plan:
- add x3,x1,x2 then sub x4,x3,x1 back-to-back -> forward_a_e=10 in the sub's EX cycle. With one nop between -> 01.
- lw x5,0(x1) then add x6,x5,x2 -> stall_f=stall_d=1 for exactly 1 cycle, EX bubble (reg_write_m=0 two cycles later), then forward_a_e=01.
- beq with zero_e=1 -> pc_src_e=1, flush_d=1, and the next EX stage shows all controls 0. bne with zero_e=1 -> pc_src_e=0.
- jal x1 -> pc_src_e=1 in EX, then 3 cycles after decode result_src_w=10, reg_write_w=1, rd_w=1.
- lw x0 followed by a use of x0 -> no stall. Opcode 7'h7F -> illegal_d=1 and no writes reach WB.
- Assert rst mid-stream with reg_write in MEM -> reg_write_w=0 immediately and all outputs 0 while reset is held.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined control unit.
// Opcode constants, select encodings and the per-stage bundles live here.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Full bundle decoded in ID and held in ID/EX.
    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        jalr;
        logic        alu_src;
        alu_ctrl_e   alu_control;
        logic [2:0]  funct3;
    } ctrl_bundle_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
    } mem_bundle_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
    } wb_bundle_t;

    localparam int CTRL_W     = $bits(ctrl_bundle_t);
    localparam int MEM_CTRL_W = $bits(mem_bundle_t);
    localparam int WB_CTRL_W  = $bits(wb_bundle_t);

    // alt selects sub/sra; the caller decides when funct7[5] is meaningful.
    function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic alt);
        alu_ctrl_e res;
        case (funct3)
            3'b000:  res = alt ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = alt ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipe_main_alu_decoder.sv
// Combinational ID-stage decode of opcode/funct fields into the control bundle.
// Unknown opcodes produce an all-zero bundle and raise illegal.
module pipe_main_alu_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl,
    output logic [2:0]   imm_src,
    output logic         illegal
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        ctrl        = '0;
        imm_src     = IMM_I;
        illegal     = 1'b0;
        ctrl.funct3 = funct3;
        case (op)
            OP_R: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = alu_decode(funct3, funct7[5]);
            end
            OP_I: begin
                // Only srai uses funct7[5]; addi with that bit set is still add.
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = alu_decode(funct3, funct7[5] && (funct3 == F3_SR));
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                imm_src          = IMM_B;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_U;
            end
            default: begin
                ctrl    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Five-stage control pipeline: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use / RAW hazard detection, branch resolution and EX operand forwarding.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op_d,
    input  logic [2:0]            funct3_d,
    input  logic [6:0]            funct7_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  zero_e,
    output logic [2:0]            imm_src_d,
    output logic                  illegal_d,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_e,
    output logic                  pc_src_e,
    output logic                  jalr_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  mem_write_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d
);

    ctrl_bundle_t dec_ctrl;
    logic         dec_illegal;

    pipe_main_alu_decoder u_decoder (
        .op      (op_d),
        .funct3  (funct3_d),
        .funct7  (funct7_d),
        .ctrl    (dec_ctrl),
        .imm_src (imm_src_d),
        .illegal (dec_illegal)
    );

    ctrl_bundle_t          ex_ctl_q, ex_ctl_d;
    mem_bundle_t           mem_ctl_q, mem_ctl_d;
    wb_bundle_t            wb_ctl_q, wb_ctl_d;
    logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
    logic [REG_ADDR_W-1:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;

    logic       branch_taken, lw_stall, raw_stall, stall, bubble_ex;
    logic [1:0] fwd_a, fwd_b;

    always_comb begin
        branch_taken = 1'b0;
        case (ex_ctl_q.funct3)
            F3_BEQ:  branch_taken = zero_e;
            F3_BNE:  branch_taken = ~zero_e;
            default: branch_taken = 1'b0;
        endcase
        pc_src_e = ex_ctl_q.jump | (ex_ctl_q.branch & branch_taken);
    end

    assign lw_stall = (ex_ctl_q.result_src == RES_MEM) && (rd_e_q != '0)
                      && ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));

    if (FORWARD_EN) begin : g_fwd
        assign raw_stall = 1'b0;

        // MEM result is younger than WB, so it takes priority.
        always_comb begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
            if (mem_ctl_q.reg_write && (rd_m_q != '0) && (rd_m_q == rs1_e_q))
                fwd_a = FWD_MEM;
            else if (wb_ctl_q.reg_write && (rd_w_q != '0) && (rd_w_q == rs1_e_q))
                fwd_a = FWD_WB;
            if (mem_ctl_q.reg_write && (rd_m_q != '0) && (rd_m_q == rs2_e_q))
                fwd_b = FWD_MEM;
            else if (wb_ctl_q.reg_write && (rd_w_q != '0) && (rd_w_q == rs2_e_q))
                fwd_b = FWD_WB;
        end
    end else begin : g_nofwd
        logic hit_e, hit_m, hit_w;
        assign hit_e = ex_ctl_q.reg_write && (rd_e_q != '0) && ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));
        assign hit_m = mem_ctl_q.reg_write && (rd_m_q != '0) && ((rd_m_q == rs1_d) || (rd_m_q == rs2_d));
        assign hit_w = wb_ctl_q.reg_write && (rd_w_q != '0) && ((rd_w_q == rs1_d) || (rd_w_q == rs2_d));
        assign raw_stall = hit_e | hit_m | hit_w;
        assign fwd_a     = FWD_RF;
        assign fwd_b     = FWD_RF;
    end

    assign stall     = lw_stall | raw_stall;
    assign bubble_ex = stall | pc_src_e | dec_illegal;

    always_comb begin
        if (bubble_ex) begin
            ex_ctl_d = '0;
            rs1_e_d  = '0;
            rs2_e_d  = '0;
            rd_e_d   = '0;
        end else begin
            ex_ctl_d = dec_ctrl;
            rs1_e_d  = rs1_d;
            rs2_e_d  = rs2_d;
            rd_e_d   = rd_d;
        end
        mem_ctl_d.reg_write  = ex_ctl_q.reg_write;
        mem_ctl_d.result_src = ex_ctl_q.result_src;
        mem_ctl_d.mem_write  = ex_ctl_q.mem_write;
        rd_m_d               = rd_e_q;
        wb_ctl_d.reg_write   = mem_ctl_q.reg_write;
        wb_ctl_d.result_src  = mem_ctl_q.result_src;
        rd_w_d               = rd_m_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctl_q  <= '0;
            rs1_e_q   <= '0;
            rs2_e_q   <= '0;
            rd_e_q    <= '0;
            mem_ctl_q <= '0;
            rd_m_q    <= '0;
            wb_ctl_q  <= '0;
            rd_w_q    <= '0;
        end else begin
            ex_ctl_q  <= ex_ctl_d;
            rs1_e_q   <= rs1_e_d;
            rs2_e_q   <= rs2_e_d;
            rd_e_q    <= rd_e_d;
            mem_ctl_q <= mem_ctl_d;
            rd_m_q    <= rd_m_d;
            wb_ctl_q  <= wb_ctl_d;
            rd_w_q    <= rd_w_d;
        end
    end

    assign illegal_d     = dec_illegal;
    assign alu_control_e = ALU_CTRL_W'(ex_ctl_q.alu_control);
    assign alu_src_e     = ex_ctl_q.alu_src;
    assign jalr_e        = ex_ctl_q.jalr;
    assign forward_a_e   = fwd_a;
    assign forward_b_e   = fwd_b;
    assign mem_write_m   = mem_ctl_q.mem_write;
    assign reg_write_w   = wb_ctl_q.reg_write;
    assign result_src_w  = wb_ctl_q.result_src;
    assign rd_w          = rd_w_q;
    assign stall_f       = stall;
    assign stall_d       = stall;
    assign flush_d       = pc_src_e;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench: directed hazard/branch/reset scenarios plus randomized
// instruction streams compared every cycle against an instruction-level model.
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op_d = '0, funct7_d = '0;
    logic [2:0] funct3_d = '0;
    logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
    logic       zero_e = 1'b0;

    logic [2:0] imm_src_d;
    logic       illegal_d, alu_src_e, pc_src_e, jalr_e, mem_write_m, reg_write_w;
    logic [3:0] alu_control_e;
    logic [1:0] forward_a_e, forward_b_e, result_src_w;
    logic [4:0] rd_w;
    logic       stall_f, stall_d, flush_d;

    always #5 clk = ~clk;

    pipe_control_unit dut (
        .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .zero_e(zero_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d), .alu_control_e(alu_control_e),
        .alu_src_e(alu_src_e), .pc_src_e(pc_src_e), .jalr_e(jalr_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .mem_write_m(mem_write_m),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
    );

    int checks = 0;
    int failures = 0;

    // One in-flight instruction as the model sees it.
    typedef struct {
        int rw, rsrc, mw, jump, br, jalr, asrc, alu, f3, rs1, rs2, rd;
    } instr_t;

    localparam int ALU_TBL [0:7] = '{0, 7, 5, 6, 4, 8, 3, 2};

    instr_t ex_s, mem_s, wb_s, ex_n, mem_n, wb_n;
    int     stall_exp = 0;
    int     flush_exp = 0;

    function automatic instr_t empty_instr();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                       output instr_t d, output int ill, output int imm);
        d   = '{default: 0};
        ill = 0;
        imm = 0;
        case (op)
            7'h33: begin
                d.rw  = 1;
                d.alu = (f7[5] && f3 == 0) ? 1 : (f7[5] && f3 == 5) ? 9 : ALU_TBL[f3];
            end
            7'h13: begin
                d.rw = 1; d.asrc = 1;
                d.alu = (f7[5] && f3 == 5) ? 9 : ALU_TBL[f3];
            end
            7'h03: begin d.rw = 1; d.asrc = 1; d.rsrc = 1; end
            7'h23: begin d.mw = 1; d.asrc = 1; imm = 1; end
            7'h63: begin d.br = 1; d.alu = 1; imm = 2; end
            7'h6F: begin d.jump = 1; d.rw = 1; d.rsrc = 2; imm = 3; end
            7'h67: begin d.jump = 1; d.jalr = 1; d.rw = 1; d.asrc = 1; d.rsrc = 2; end
            7'h37: begin d.rw = 1; d.asrc = 1; imm = 4; end
            default: ill = 1;
        endcase
        if (ill == 0) d.f3 = int'(f3);
    endfunction

    function automatic int fwd_src(input int r);
        if (mem_s.rw != 0 && mem_s.rd != 0 && mem_s.rd == r) return 2;
        if (wb_s.rw != 0 && wb_s.rd != 0 && wb_s.rd == r) return 1;
        return 0;
    endfunction

    // Compare every output with the model for the current cycle, then compute
    // what each stage holds after the next edge.
    task automatic model_eval();
        instr_t d;
        int ill, imm, pcs, lws;
        ref_decode(op_d, funct3_d, funct7_d, d, ill, imm);
        d.rs1 = int'(rs1_d); d.rs2 = int'(rs2_d); d.rd = int'(rd_d);
        pcs = ex_s.jump;
        if (ex_s.br != 0 && ex_s.f3 == 0 && zero_e) pcs = 1;
        if (ex_s.br != 0 && ex_s.f3 == 1 && !zero_e) pcs = 1;
        lws = (ex_s.rsrc == 1 && ex_s.rd != 0 && (ex_s.rd == d.rs1 || ex_s.rd == d.rs2)) ? 1 : 0;

        chk("imm_src_d", imm_src_d, imm);
        chk("illegal_d", illegal_d, ill);
        chk("alu_control_e", alu_control_e, ex_s.alu);
        chk("alu_src_e", alu_src_e, ex_s.asrc);
        chk("jalr_e", jalr_e, ex_s.jalr);
        chk("pc_src_e", pc_src_e, pcs);
        chk("forward_a_e", forward_a_e, fwd_src(ex_s.rs1));
        chk("forward_b_e", forward_b_e, fwd_src(ex_s.rs2));
        chk("mem_write_m", mem_write_m, mem_s.mw);
        chk("reg_write_w", reg_write_w, wb_s.rw);
        chk("result_src_w", result_src_w, wb_s.rsrc);
        chk("rd_w", rd_w, wb_s.rd);
        chk("stall_f", stall_f, lws);
        chk("stall_d", stall_d, lws);
        chk("flush_d", flush_d, pcs);

        wb_n      = mem_s;
        mem_n     = ex_s;
        ex_n      = (lws != 0 || pcs != 0 || ill != 0) ? empty_instr() : d;
        stall_exp = lws;
        flush_exp = pcs;
    endtask

    // Returns at the falling edge of the cycle in which this instruction sits in ID.
    task automatic issue(input int op, input int f3, input int f7, input int r1,
                         input int r2, input int rd, input int z);
        @(posedge clk);
        ex_s = ex_n; mem_s = mem_n; wb_s = wb_n;
        #1;
        op_d = 7'(op); funct3_d = 3'(f3); funct7_d = 7'(f7);
        rs1_d = 5'(r1); rs2_d = 5'(r2); rd_d = 5'(rd); zero_e = 1'(z);
        @(negedge clk);
        model_eval();
    endtask

    task automatic nop();
        issue(32'h13, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        repeat (3) nop();
    endtask

    task automatic clear_model();
        ex_s = empty_instr(); mem_s = empty_instr(); wb_s = empty_instr();
        ex_n = empty_instr(); mem_n = empty_instr(); wb_n = empty_instr();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reg_write_w"}, reg_write_w, 0);
        chk({tag, "_result_src_w"}, result_src_w, 0);
        chk({tag, "_rd_w"}, rd_w, 0);
        chk({tag, "_mem_write_m"}, mem_write_m, 0);
        chk({tag, "_alu_control_e"}, alu_control_e, 0);
        chk({tag, "_alu_src_e"}, alu_src_e, 0);
        chk({tag, "_pc_src_e"}, pc_src_e, 0);
        chk({tag, "_jalr_e"}, jalr_e, 0);
        chk({tag, "_fwd_a"}, forward_a_e, 0);
        chk({tag, "_fwd_b"}, forward_b_e, 0);
        chk({tag, "_stall_f"}, stall_f, 0);
        chk({tag, "_flush_d"}, flush_d, 0);
    endtask

    initial begin
        int op, f3, f7, r1, r2, rd, z, k;

        // Power-on reset with a jal in ID: nothing may enter the pipe while held.
        clear_model();
        op_d = 7'h6F; rd_d = 5'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("por");
        op_d = 7'h13; rd_d = 5'd0;
        rst = 1'b0;
        #1 model_eval();

        // ALU result forwarded from MEM, then from WB.
        drain();
        issue(32'h33, 0, 0, 1, 2, 3, 0);
        issue(32'h33, 0, 32, 3, 1, 4, 0);
        nop();
        chk("lit_fwd_mem_a", forward_a_e, 2'b10);
        chk("lit_sub_alu", alu_control_e, 4'b0001);
        drain();
        issue(32'h33, 0, 0, 1, 2, 3, 0);
        nop();
        issue(32'h33, 0, 32, 3, 1, 4, 0);
        nop();
        chk("lit_fwd_wb_a", forward_a_e, 2'b01);

        // Load-use: one stall cycle, bubble, then WB forward.
        drain();
        issue(32'h03, 2, 0, 1, 0, 5, 0);
        issue(32'h33, 0, 0, 5, 2, 6, 0);
        chk("lit_lw_stall_f", stall_f, 1);
        chk("lit_lw_stall_d", stall_d, 1);
        issue(32'h33, 0, 0, 5, 2, 6, 0);
        chk("lit_lw_stall_clear", stall_f, 0);
        chk("lit_lw_bubble_alu_src", alu_src_e, 0);
        nop();
        chk("lit_lw_fwd_wb", forward_a_e, 2'b01);
        chk("lit_lw_rd_w", rd_w, 5);
        chk("lit_lw_result_src_w", result_src_w, 2'b01);
        nop();
        chk("lit_bubble_wb", reg_write_w, 0);

        // Taken beq flushes the younger addi; bne with zero set does not redirect.
        drain();
        issue(32'h63, 0, 0, 1, 2, 0, 0);
        issue(32'h13, 0, 0, 1, 0, 7, 1);
        chk("lit_beq_pc_src", pc_src_e, 1);
        chk("lit_beq_flush", flush_d, 1);
        nop();
        chk("lit_flushed_alu_src", alu_src_e, 0);
        chk("lit_flushed_pc_src", pc_src_e, 0);
        issue(32'h63, 1, 0, 1, 2, 0, 0);
        issue(32'h13, 0, 0, 0, 0, 0, 1);
        chk("lit_bne_not_taken", pc_src_e, 0);

        // jal writes PC+4 to x1 three cycles after decode.
        drain();
        issue(32'h6F, 0, 0, 0, 0, 1, 0);
        nop();
        chk("lit_jal_pc_src", pc_src_e, 1);
        nop();
        nop();
        chk("lit_jal_result_src_w", result_src_w, 2'b10);
        chk("lit_jal_reg_write_w", reg_write_w, 1);
        chk("lit_jal_rd_w", rd_w, 1);

        // x0 is never a hazard; illegal opcode never writes.
        drain();
        issue(32'h03, 2, 0, 1, 0, 0, 0);
        issue(32'h33, 0, 0, 0, 2, 6, 0);
        chk("lit_x0_no_stall", stall_f, 0);
        issue(32'h7F, 0, 0, 1, 2, 9, 0);
        chk("lit_illegal", illegal_d, 1);
        nop();
        nop();
        nop();
        chk("lit_illegal_no_write", reg_write_w, 0);

        // Asynchronous reset while an add sits in MEM.
        drain();
        issue(32'h33, 0, 0, 1, 2, 3, 0);
        nop();
        nop();
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(posedge clk);
        #1 chk("midrst_hold_reg_write_w", reg_write_w, 0);
        chk("midrst_hold_rd_w", rd_w, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        #1 model_eval();

        // Randomized stream; the fetched instruction holds while stalled.
        op = 32'h13; f3 = 0; f7 = 0; r1 = 0; r2 = 0; rd = 0;
        repeat (600) begin
            if (!(stall_exp != 0 && flush_exp == 0)) begin
                k  = $urandom_range(0, 10);
                f3 = $urandom_range(0, 7);
                f7 = ($urandom_range(0, 1) != 0) ? 32 : 0;
                r1 = $urandom_range(0, 3);
                r2 = $urandom_range(0, 3);
                rd = $urandom_range(0, 3);
                case (k)
                    0, 1: op = 32'h33;
                    2:    op = 32'h13;
                    3:    begin op = 32'h03; f3 = 2; end
                    4:    begin op = 32'h23; f3 = 2; end
                    5:    begin op = 32'h63; f3 = ($urandom_range(0, 2) == 2) ? 4 : $urandom_range(0, 1); end
                    6:    op = 32'h6F;
                    7:    begin op = 32'h67; f3 = 0; end
                    8:    op = 32'h37;
                    9:    begin op = 32'h13; f3 = 5; end
                    default: begin
                        k  = $urandom_range(0, 2);
                        op = (k == 0) ? 32'h7F : (k == 1) ? 32'h00 : 32'h0F;
                    end
                endcase
            end
            z = $urandom_range(0, 1);
            issue(op, f3, f7, r1, r2, rd, z);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
